seq_div: RTL and testbench

//  Iterative restoring divider: the inverse of the multiplier path. It takes a 2*WIDTH-bit dividend
//  (a product from the multiplier path) and a WIDTH-bit divisor. It returns the quotient and remainder.

---
 rtl/seq_div_if.sv | 25 ++
 rtl/seq_div.sv | 126 ++++++++++++
 tb/tb_seq_div.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seq_div_if.sv
// seq_div_if: request/response bundle for the sequential divider.
//   master (requester): drives in_valid/in_dividend/in_divisor and observes in_ready and results.
//   slave (divider):    consumes the request and drives in_ready, out_valid, out_quotient,
//                       out_remainder and out_div_by_zero.
// The dividend and quotient are 2*WIDTH bits wide. The divisor and remainder are WIDTH bits wide.
interface seq_div_if #(parameter int WIDTH = 4);
  logic                 in_valid;
  logic [2*WIDTH-1:0]   in_dividend;
  logic [WIDTH-1:0]     in_divisor;
  logic                 in_ready;
  logic                 out_valid;
  logic [2*WIDTH-1:0]   out_quotient;
  logic [WIDTH-1:0]     out_remainder;
  logic                 out_div_by_zero;

  modport master (
    output in_valid, in_dividend, in_divisor,
    input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor,
    output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// seq_div: iterative restoring divider with a fixed latency that does not depend on the data.
// It processes one quotient bit per cycle, starting from the dividend MSB.
//   clk  - single clock; all state updates happen on posedge
//   rst  - synchronous, active-high; aborts any request in flight
//   bus  - seq_div_if slave port:
//          in_valid/in_dividend/in_divisor  request; accepted when in_ready=1 (IDLE only)
//          out_valid                        one-cycle pulse in DONE
//          out_quotient/out_remainder       result; held until the next completion
//          out_div_by_zero                  set when the completed request had divisor==0
// Timing: if a request is accepted in cycle k, out_valid is 1 in cycle k+2*WIDTH+1.
// Zero or trivial operands never take an early exit.
module seq_div #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_div_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  rem;
  logic [DW-1:0]   dvd;
  logic [WIDTH-1:0] dvs;
  logic [DW-1:0]   quo;

  logic [DW-1:0]    q_out;
  logic [WIDTH-1:0] r_out;
  logic             z_out;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic [DW-1:0]    step_quo;

  // The dividend stays intact and is indexed MSB-first by cnt.
  // This keeps its low bits available for the divide-by-zero remainder.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], dvd[LAST - cnt]};
    step_bit = 1'b0;
    step_rem = shifted;
    if (shifted >= {1'b0, dvs}) begin
      step_bit = 1'b1;
      step_rem = shifted - {1'b0, dvs};
    end
    step_quo = {quo[DW-2:0], step_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = CALC;
      end
      CALC: begin
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The result registers are loaded on the final CALC edge, so they are already valid
  // while out_valid is high in DONE. They do not change at any other time.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      quo   <= '0;
      q_out <= '0;
      r_out <= '0;
      z_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd <= bus.in_dividend;
            dvs <= bus.in_divisor;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          rem <= step_rem;
          quo <= step_quo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            if (dvs == '0) begin
              q_out <= '1;
              r_out <= dvd[WIDTH-1:0];
              z_out <= 1'b1;
            end else begin
              q_out <= step_quo;
              r_out <= step_rem[WIDTH-1:0];
              z_out <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_quotient    = q_out;
  assign bus.out_remainder   = r_out;
  assign bus.out_div_by_zero = z_out;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed self-checking bench for seq_div (WIDTH=4).
// It checks the reset state, latency, results, divide-by-zero handling,
// in_valid while busy, and a mid-operation reset.
// It also sweeps all dividend/divisor pairs against integer division.
module tb_seq_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  seq_div_if #(.WIDTH(4)) bus ();

  seq_div #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge. Inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue a one-cycle request, then measure cycles to out_valid and check the results.
  // Finally confirm that the pulse ends and the results are held.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] exp_q, input logic [3:0] exp_r, input logic exp_z);
    int lat;
    check({tag, " ready"}, bus.in_ready, 1);
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 9);
    check({tag, " quotient"}, bus.out_quotient, exp_q);
    check({tag, " remainder"}, bus.out_remainder, exp_r);
    check({tag, " dbz"}, bus.out_div_by_zero, exp_z);
    tick();
    check({tag, " pulse end"}, bus.out_valid, 0);
    check({tag, " q held"}, bus.out_quotient, exp_q);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst ready", bus.in_ready, 1);
    check("rst valid", bus.out_valid, 0);
    check("rst q", bus.out_quotient, 0);
    check("rst r", bus.out_remainder, 0);
    check("rst dbz", bus.out_div_by_zero, 0);
    tick();

    // Basic vectors, including the trivial and zero operands
    run_div("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    run_div("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    run_div("0/5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0);
    run_div("100/0", 8'd100, 4'd0, 8'hFF, 4'd4, 1'b1);
    run_div("16/4", 8'd16, 4'd4, 8'd4, 4'd0, 1'b0);

    // Hold in_valid high while the divider is busy; the second request waits for IDLE
    bus.in_valid    = 1'b1;
    bus.in_dividend = 8'd50;
    bus.in_divisor  = 4'd3;
    tick();
    bus.in_dividend = 8'd99;
    bus.in_divisor  = 4'd9;
    for (int c = 1; c <= 8; c++) begin
      check("busy ready", bus.in_ready, 0);
      check("busy valid", bus.out_valid, 0);
      check("busy q held", bus.out_quotient, 4);
      tick();
    end
    check("done ready", bus.in_ready, 0);
    check("50/3 valid", bus.out_valid, 1);
    check("50/3 quotient", bus.out_quotient, 16);
    check("50/3 remainder", bus.out_remainder, 2);
    tick();
    check("c10 ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    begin
      int lat;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
        tick();
        lat++;
      end
      check("99/9 latency", lat, 9);
      check("99/9 quotient", bus.out_quotient, 11);
      check("99/9 remainder", bus.out_remainder, 0);
    end
    tick();

    // A mid-operation reset aborts the request
    bus.in_valid    = 1'b1;
    bus.in_dividend = 8'd120;
    bus.in_divisor  = 4'd11;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ready", bus.in_ready, 1);
    check("abort valid", bus.out_valid, 0);
    check("abort q", bus.out_quotient, 0);
    check("abort r", bus.out_remainder, 0);
    check("abort dbz", bus.out_div_by_zero, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("abort no valid", bus.out_valid, 0);
    end
    run_div("120/11", 8'd120, 4'd11, 8'd10, 4'd10, 1'b0);

    // Full operand sweep against integer division
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [7:0] av;
        logic [7:0] eq;
        logic [3:0] er;
        av = 8'(a);
        if (b == 0) begin
          eq = 8'hFF;
          er = av[3:0];
        end else begin
          eq = 8'(a / b);
          er = 4'(a % b);
        end
        run_div("sweep", av, 4'(b), eq, er, (b == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
